alarm_bank: RTL
===============

# alarm_bank

Multi-slot alarm store with per-field increment/decrement, press-and-hold auto-repeat, per-slot enable and time-match detection. Sits between the button debouncers and the alarm sounder; the timekeeping counter supplies current time. It generalises single-alarm setting to `NUM_ALARMS` independently armed slots, each of which raises a one-cycle hit pulse when the current time matches it.

## Interface
- `NUM_ALARMS`, 4: number of alarm slots (1–8).
- `HOLD_CYCLES`, 500: cycles a button must stay high after its first step before auto-repeat starts (≥2).
- `REPEAT_CYCLES`, 100: cycles between auto-repeat steps (≥1).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `alarm_mode` in 1: edit enable; all editing is ignored while low.
- `sel_next` in 1: level; its rising edge advances the selected slot.
- `dec` in 1: level; 1 means step down, 0 means step up.
- `inc_hours`, `inc_minutes`, `inc_seconds` in 1 each: debounced field buttons (level).
- `toggle_en` in 1: level; its rising edge toggles the enable bit of the selected slot.
- `cur_hours` in 5, `cur_minutes` in 6, `cur_seconds` in 6: current time.
- `sel_idx` out $clog2(NUM_ALARMS) (min 1): selected slot.
- `alarm_hours` out 5*NUM_ALARMS, `alarm_minutes` out 6*NUM_ALARMS, `alarm_seconds` out 6*NUM_ALARMS: packed slot values, slot i at `[i*W +: W]`.
- `alarm_enabled` out NUM_ALARMS: per-slot arm bits.
- `alarm_hit` out NUM_ALARMS: one-cycle match pulses.

## Operation
- Reset: every slot is set to 00:00:00, `alarm_enabled`=0, `sel_idx`=0, `alarm_hit`=0, and all edge registers and repeat engines go to IDLE.
- Edge detection: the previous value of each level input is registered. A rising edge is input=1 with prev=0.
- `sel_next` edge: `sel_idx` wraps from NUM_ALARMS-1 to 0. A step on the same edge applies to the old slot.
- `toggle_en` edge: flips `alarm_enabled[sel_idx]`.
- Each field has its own repeat engine with states IDLE, HOLD and REPEAT, plus a counter.
  - IDLE→HOLD on a rising edge; one step is issued and the counter is cleared.
  - HOLD: the counter increments while the button is held. When it reaches HOLD_CYCLES-1, one step is issued, the counter is cleared, and the engine moves to REPEAT.
  - REPEAT: one step is issued each time the counter reaches REPEAT_CYCLES-1, then the counter is cleared.
  - The engine returns to IDLE whenever its button is low.
- Step arithmetic is modulo the field range:
  - Hours are 0–23 and wrap 23↔0.
  - Minutes and seconds are 0–59 and wrap 59↔0.
  - Direction is taken from `dec` at the step edge.
  - No carry between fields.
- Simultaneous field steps all apply in the same cycle.
- `alarm_mode` low:
  - All engines are forced to IDLE.
  - No steps, selection changes or toggles occur.
  - Edge registers still track their inputs, so a button held across the mode rising edge does not step.
- Match detection:
  - `match[i]` = `alarm_enabled[i]` & (slot i == current time) & !`alarm_mode`. It is registered each cycle.
  - `alarm_hit[i]` = match & !prev_match, so it fires once per match interval.
  - All slots are evaluated in parallel. Several hits in the same cycle are allowed.

## Timing
- Step latency: a rising edge sampled at posedge N updates the field at N; the new value is visible after N.
- Held button: steps occur at edges N, N+HOLD_CYCLES, then every REPEAT_CYCLES.
- Hit latency: current time equal to the slot at edge N makes `alarm_hit` high during cycle N+1, for one cycle.
- An edit that makes a slot equal to the current time yields no hit while `alarm_mode`=1. A hit occurs when `alarm_mode` falls, if the slot still matches.
- Reset asserted mid-hold or mid-hit: outputs clear immediately (asynchronous). No pulse occurs after release until a fresh edge.

## Configuration
- `ALARM_AUTOREPEAT_EN` defined: HOLD and REPEAT behave as above.
- `ALARM_AUTOREPEAT_EN` undefined: exactly one step per rising edge. HOLD_CYCLES and REPEAT_CYCLES are ignored and no repeat counters are built.

## Test plan
- Reset, then `alarm_mode`=1 and pulse `inc_hours` 24 times with `dec`=0: slot 0 hours goes 0→23→0, and other slots stay 00:00:00.
- `dec`=1, one `inc_minutes` pulse from 0: minutes=59. One `inc_seconds` pulse from 0: seconds=59.
- HOLD_CYCLES=4, REPEAT_CYCLES=2, `inc_seconds` held 10 cycles (autorepeat build): steps at cycles 0, 4, 6 and 8, giving seconds=4. Non-autorepeat build: seconds=1.
- Pulse `sel_next` 4 times with NUM_ALARMS=4: `sel_idx` goes 1, 2, 3, 0. With `sel_idx`=2, pulse `toggle_en`: `alarm_enabled`=4'b0100.
- Slot 2 set to 07:30:15 and enabled, `alarm_mode`=0, current time held at 07:30:15 for 5 cycles: `alarm_hit`=4'b0100 for exactly one cycle, the cycle after first equality. Disabled slot 1 at the same time: no hit.
- Assert `reset` while `inc_minutes` is held in REPEAT: all outputs are 0 immediately. After release with the button still high, no step occurs until a new rising edge.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-slot alarm store: field stepping with optional press-and-hold auto-repeat
// (enabled by defining ALARM_AUTOREPEAT_EN), per-slot arming and time-match pulses.
module alarm_bank #(
  parameter int NUM_ALARMS    = 4,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alarm_mode,
  input  logic                    sel_next,
  input  logic                    dec,
  input  logic                    inc_hours,
  input  logic                    inc_minutes,
  input  logic                    inc_seconds,
  input  logic                    toggle_en,
  input  logic [4:0]              cur_hours,
  input  logic [5:0]              cur_minutes,
  input  logic [5:0]              cur_seconds,
  output logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] sel_idx,
  output logic [5*NUM_ALARMS-1:0] alarm_hours,
  output logic [6*NUM_ALARMS-1:0] alarm_minutes,
  output logic [6*NUM_ALARMS-1:0] alarm_seconds,
  output logic [NUM_ALARMS-1:0]   alarm_enabled,
  output logic [NUM_ALARMS-1:0]   alarm_hit
);

  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_ALARMS - 1);

  if (NUM_ALARMS < 1 || NUM_ALARMS > 8 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("alarm_bank: parameter out of range");
  end

  function automatic logic [4:0] step_hours(input logic [4:0] v, input logic down);
    if (down) return (v == 5'd0) ? 5'd23 : v - 5'd1;
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic down);
    if (down) return (v == 6'd0) ? 6'd59 : v - 6'd1;
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  logic [4:0]       hours_p0   [NUM_ALARMS];
  logic [5:0]       minutes_p0 [NUM_ALARMS];
  logic [5:0]       seconds_p0 [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] enabled_p0;
  logic [NUM_ALARMS-1:0] match_p0;
  logic [NUM_ALARMS-1:0] match_now;
  logic [SEL_W-1:0] sel_p0;

  // field index 0 = hours, 1 = minutes, 2 = seconds
  logic [2:0] btn;
  logic [2:0] btn_prev_p0;
  logic [2:0] btn_rise;
  logic [2:0] step;
  logic       sel_prev_p0;
  logic       tog_prev_p0;
  logic       sel_rise;
  logic       tog_rise;

  assign btn      = {inc_seconds, inc_minutes, inc_hours};
  assign btn_rise = btn & ~btn_prev_p0;
  assign sel_rise = alarm_mode & sel_next & ~sel_prev_p0;
  assign tog_rise = alarm_mode & toggle_en & ~tog_prev_p0;

`ifdef ALARM_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  rpt_state_t       state_p0 [3];
  rpt_state_t       state_nx [3];
  logic [CNT_W-1:0] cnt_p0   [3];
  logic [CNT_W-1:0] cnt_nx   [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < 3; f++) begin
        state_p0[f] <= IDLE;
        cnt_p0[f]   <= '0;
      end
    end else begin
      for (int f = 0; f < 3; f++) begin
        state_p0[f] <= state_nx[f];
        cnt_p0[f]   <= cnt_nx[f];
      end
    end
  end

  always_comb begin
    step = '0;
    for (int f = 0; f < 3; f++) begin
      state_nx[f] = state_p0[f];
      cnt_nx[f]   = cnt_p0[f];
      if (!alarm_mode || !btn[f]) begin
        state_nx[f] = IDLE;
        cnt_nx[f]   = '0;
      end else begin
        case (state_p0[f])
          IDLE: if (btn_rise[f]) begin
            step[f]     = 1'b1;
            state_nx[f] = HOLD;
            cnt_nx[f]   = '0;
          end
          HOLD: if (cnt_p0[f] == HOLD_LAST) begin
            step[f]     = 1'b1;
            state_nx[f] = REPEAT;
            cnt_nx[f]   = '0;
          end else begin
            cnt_nx[f] = cnt_p0[f] + 1'b1;
          end
          REPEAT: if (cnt_p0[f] == REPEAT_LAST) begin
            step[f]   = 1'b1;
            cnt_nx[f] = '0;
          end else begin
            cnt_nx[f] = cnt_p0[f] + 1'b1;
          end
          default: begin
            state_nx[f] = IDLE;
            cnt_nx[f]   = '0;
          end
        endcase
      end
    end
  end
`else
  assign step = btn_rise & {3{alarm_mode}};
`endif

  always_comb begin
    match_now = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_now[i] = enabled_p0[i] && !alarm_mode && (hours_p0[i] == cur_hours) &&
                     (minutes_p0[i] == cur_minutes) && (seconds_p0[i] == cur_seconds);
    end
  end

  // Edge history resets high so a button still held when reset releases cannot step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hours_p0[i]   <= '0;
        minutes_p0[i] <= '0;
        seconds_p0[i] <= '0;
      end
      enabled_p0  <= '0;
      match_p0    <= '0;
      alarm_hit   <= '0;
      sel_p0      <= '0;
      btn_prev_p0 <= '1;
      sel_prev_p0 <= 1'b1;
      tog_prev_p0 <= 1'b1;
    end else begin
      btn_prev_p0 <= btn;
      sel_prev_p0 <= sel_next;
      tog_prev_p0 <= toggle_en;
      match_p0    <= match_now;
      alarm_hit   <= match_now & ~match_p0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (SEL_W'(i) == sel_p0) begin
          if (step[0]) hours_p0[i]   <= step_hours(hours_p0[i], dec);
          if (step[1]) minutes_p0[i] <= step_sixty(minutes_p0[i], dec);
          if (step[2]) seconds_p0[i] <= step_sixty(seconds_p0[i], dec);
          if (tog_rise) enabled_p0[i] <= ~enabled_p0[i];
        end
      end
      if (sel_rise) sel_p0 <= (sel_p0 == LAST_SEL) ? '0 : sel_p0 + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_pack
    assign alarm_hours[i*5 +: 5]   = hours_p0[i];
    assign alarm_minutes[i*6 +: 6] = minutes_p0[i];
    assign alarm_seconds[i*6 +: 6] = seconds_p0[i];
  end

  assign sel_idx       = sel_p0;
  assign alarm_enabled = enabled_p0;

endmodule
